// File: rtl/atm_pkg.sv
// Shared ATM panel codes, also used by the ATM controller.
package atm_pkg;

    localparam int unsigned CARD_W    = 2;
    localparam int unsigned MENU_W    = 3;
    localparam int unsigned MENU_BTNS = 5;
    localparam int unsigned AMOUNT_W  = 4;

    typedef enum logic [CARD_W-1:0] {
        NO_CARD      = 2'b00,
        CARD_INVALID = 2'b01,
        CARD_VALID   = 2'b10
    } card_code_t;

    typedef enum logic [MENU_W-1:0] {
        MENU_NONE     = 3'b000,
        MENU_BALANCE  = 3'b001,
        MENU_RAPID    = 3'b010,
        MENU_WITHDRAW = 3'b011,
        MENU_DEPOSIT  = 3'b100,
        MENU_EXIT     = 3'b101
    } menu_code_t;

    typedef enum logic {
        ENC_IDLE,
        ENC_LOCKED
    } menu_state_t;

    // Lowest-index rising button wins.
    function automatic menu_code_t menu_encode(input logic [MENU_BTNS-1:0] rise);
        if (rise[0]) return MENU_BALANCE;
        if (rise[1]) return MENU_RAPID;
        if (rise[2]) return MENU_WITHDRAW;
        if (rise[3]) return MENU_DEPOSIT;
        if (rise[4]) return MENU_EXIT;
        return MENU_NONE;
    endfunction

endpackage

// File: rtl/panel_debounce.sv
// One-bit two-flop synchronizer plus debouncer.
// Debouncing is built only when ATM_PANEL_DEBOUNCE_EN is defined; otherwise deb follows the synchronizer.
module panel_debounce
    import atm_pkg::*;
#(
    parameter int unsigned DB_LIMIT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    localparam bit LIMIT_LEGAL = (DB_LIMIT >= 1) && (DB_LIMIT <= 65535);

    logic sync_s1;
    logic sync_s2;
    logic deb_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_s1 <= 1'b0;
            sync_s2 <= 1'b0;
        end else begin
            sync_s1 <= raw;
            sync_s2 <= sync_s1;
        end
    end

`ifdef ATM_PANEL_DEBOUNCE_EN
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] cnt;

    // Any cycle of agreement restarts the count, rejecting glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            deb_r <= 1'b0;
        end else if (sync_s2 == deb_r) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DB_LIMIT - 1)) begin
            deb_r <= sync_s2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`else
    assign deb_r = sync_s2;
`endif

    // An out-of-range limit holds the input inactive.
    assign deb = deb_r & LIMIT_LEGAL;

endmodule

// File: rtl/atm_panel_encoder.sv
// ATM front-panel encoder: synchronizes and debounces panel inputs into card, menu and confirm codes.
// Debouncing is enabled by defining ATM_PANEL_DEBOUNCE_EN.
module atm_panel_encoder
    import atm_pkg::*;
#(
    parameter int unsigned DB_LIMIT = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sw_card,
    input  logic                 sw_card_ok,
    input  logic [MENU_BTNS-1:0] btn_menu,
    input  logic                 btn_confirm,
    input  logic [AMOUNT_W-1:0]  sw_amount,
    output logic [CARD_W-1:0]    card_input,
    output logic [MENU_W-1:0]    menu_input,
    output logic                 confirm_btn,
    output logic [AMOUNT_W-1:0]  deposit_amount,
    output logic [2:0]           withdraw_amount
);

    localparam int unsigned N_CTL = MENU_BTNS + 3;

    logic [N_CTL-1:0]     raw_ctl;
    logic [N_CTL-1:0]     deb_ctl;
    logic                 deb_card;
    logic                 deb_card_ok;
    logic                 deb_confirm;
    logic [MENU_BTNS-1:0] deb_menu;
    logic [MENU_BTNS-1:0] menu_prev;
    logic [MENU_BTNS-1:0] menu_rise;
    logic                 confirm_prev;
    logic [AMOUNT_W-1:0]  amount_s1;
    menu_state_t          state;

    assign raw_ctl = {btn_confirm, btn_menu, sw_card_ok, sw_card};

    for (genvar i = 0; i < N_CTL; i++) begin : g_db
        panel_debounce #(.DB_LIMIT(DB_LIMIT)) u_db (
            .clk (clk),
            .rst (rst),
            .raw (raw_ctl[i]),
            .deb (deb_ctl[i])
        );
    end

    assign {deb_confirm, deb_menu, deb_card_ok, deb_card} = deb_ctl;
    assign menu_rise = deb_menu & ~menu_prev;

    // Amount switches are synchronized only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amount_s1       <= '0;
            deposit_amount  <= '0;
            withdraw_amount <= '0;
        end else begin
            amount_s1       <= sw_amount;
            deposit_amount  <= amount_s1;
            withdraw_amount <= amount_s1[2:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            card_input   <= NO_CARD;
            confirm_btn  <= 1'b0;
            confirm_prev <= 1'b0;
            menu_prev    <= '0;
        end else begin
            if (!deb_card)       card_input <= NO_CARD;
            else if (deb_card_ok) card_input <= CARD_VALID;
            else                 card_input <= CARD_INVALID;
            confirm_btn  <= deb_confirm & ~confirm_prev;
            confirm_prev <= deb_confirm;
            menu_prev    <= deb_menu;
        end
    end

    // One code per press; relock until every menu button is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ENC_IDLE;
            menu_input <= MENU_NONE;
        end else begin
            case (state)
                ENC_IDLE: begin
                    if (|menu_rise) begin
                        menu_input <= menu_encode(menu_rise);
                        state      <= ENC_LOCKED;
                    end else begin
                        menu_input <= MENU_NONE;
                    end
                end
                ENC_LOCKED: begin
                    menu_input <= MENU_NONE;
                    if (deb_menu == '0) state <= ENC_IDLE;
                end
                default: begin
                    menu_input <= MENU_NONE;
                    state      <= ENC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atm_panel_encoder.sv
// Scoreboard bench for atm_panel_encoder with DB_LIMIT = 4.
module tb_atm_panel_encoder;

    localparam int unsigned DB = 4;
`ifdef ATM_PANEL_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif
    localparam int LAT    = DB_EN ? int'(DB) + 3 : 3;
    localparam int K_CARD = 0;
    localparam int K_DEP  = 1;
    localparam int K_WD   = 2;

    typedef struct { int cyc; logic [2:0] menu; logic conf; } pulse_t;
    typedef struct { int cyc; int kind; logic [3:0] val; } level_t;

    pulse_t pq[$];
    level_t lq[$];
    pulse_t mp;
    level_t ml;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw_card;
    logic       sw_card_ok;
    logic [4:0] btn_menu;
    logic       btn_confirm;
    logic [3:0] sw_amount;
    logic [1:0] card_input;
    logic [2:0] menu_input;
    logic       confirm_btn;
    logic [3:0] deposit_amount;
    logic [2:0] withdraw_amount;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    atm_panel_encoder #(.DB_LIMIT(DB)) dut (
        .clk             (clk),
        .rst             (rst),
        .sw_card         (sw_card),
        .sw_card_ok      (sw_card_ok),
        .btn_menu        (btn_menu),
        .btn_confirm     (btn_confirm),
        .sw_amount       (sw_amount),
        .card_input      (card_input),
        .menu_input      (menu_input),
        .confirm_btn     (confirm_btn),
        .deposit_amount  (deposit_amount),
        .withdraw_amount (withdraw_amount)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_pulse(input int dly, input logic [2:0] m, input logic c);
        pulse_t p;
        p.cyc  = cyc + dly;
        p.menu = m;
        p.conf = c;
        pq.push_back(p);
    endtask

    task automatic exp_level(input int dly, input int k, input logic [3:0] v);
        level_t l;
        l.cyc  = cyc + dly;
        l.kind = k;
        l.val  = v;
        lq.push_back(l);
    endtask

    task automatic check_reset_outputs();
        check("rst_card",     32'(card_input),      32'd0);
        check("rst_menu",     32'(menu_input),      32'd0);
        check("rst_confirm",  32'(confirm_btn),     32'd0);
        check("rst_deposit",  32'(deposit_amount),  32'd0);
        check("rst_withdraw", 32'(withdraw_amount), 32'd0);
    endtask

    task automatic settle();
        btn_menu    = '0;
        btn_confirm = 1'b0;
        tick(LAT + 4);
    endtask

    // Compare outputs against the scoreboard every cycle; unexpected pulses are errors.
    always @(negedge clk) begin
        if (pq.size() != 0 && pq[0].cyc <= cyc) begin
            mp = pq.pop_front();
            check("menu_code",     32'(menu_input),  32'(mp.menu));
            check("confirm_pulse", 32'(confirm_btn), 32'(mp.conf));
        end else if (menu_input != 3'b000 || confirm_btn) begin
            check("spurious_pulse", 32'({menu_input, confirm_btn}), 32'd0);
        end
        while (lq.size() != 0 && lq[0].cyc <= cyc) begin
            ml = lq.pop_front();
            case (ml.kind)
                K_CARD:  check("card_input",      32'(card_input),      32'(ml.val));
                K_DEP:   check("deposit_amount",  32'(deposit_amount),  32'(ml.val));
                default: check("withdraw_amount", 32'(withdraw_amount), 32'(ml.val));
            endcase
        end
    end

    initial begin
        rst = 1'b1; sw_card = 1'b0; sw_card_ok = 1'b0;
        btn_menu = '0; btn_confirm = 1'b0; sw_amount = '0;
        tick(3);
        check_reset_outputs();
        rst = 1'b0;
        tick(LAT + 2);

        // Amount sync: old value one cycle after change, new value after two.
        sw_amount = 4'b1011;
        exp_level(1, K_DEP, 4'b0000);
        exp_level(2, K_DEP, 4'b1011);
        exp_level(2, K_WD,  4'b0011);
        tick(4);

        // Card status transitions.
        sw_card = 1'b1; sw_card_ok = 1'b0;
        exp_level(LAT - 1, K_CARD, 4'd0);
        exp_level(LAT,     K_CARD, 4'd1);
        tick(LAT + 2);
        sw_card_ok = 1'b1;
        exp_level(LAT - 1, K_CARD, 4'd1);
        exp_level(LAT,     K_CARD, 4'd2);
        tick(LAT + 2);
        sw_card = 1'b0;
        exp_level(LAT - 1, K_CARD, 4'd2);
        exp_level(LAT,     K_CARD, 4'd0);
        tick(LAT + 2);
        sw_card_ok = 1'b0;
        exp_level(LAT, K_CARD, 4'd0);
        tick(LAT + 2);

        // Withdraw held long: one code only.
        btn_menu = 5'b00100;
        exp_pulse(LAT, 3'b011, 1'b0);
        tick(20);
        settle();

        // Simultaneous press resolves low; lock holds until all released.
        btn_menu = 5'b10010;
        exp_pulse(LAT, 3'b010, 1'b0);
        tick(LAT + 3);
        btn_menu = 5'b10000;
        tick(LAT + 4);
        btn_menu = 5'b00000;
        tick(LAT + 4);
        btn_menu = 5'b10000;
        exp_pulse(LAT, 3'b101, 1'b0);
        tick(LAT + 3);
        settle();

        // Menu, confirm and card change in the same cycle.
        btn_menu = 5'b00001; btn_confirm = 1'b1; sw_card = 1'b1; sw_card_ok = 1'b1;
        exp_pulse(LAT, 3'b001, 1'b1);
        exp_level(LAT, K_CARD, 4'd2);
        tick(LAT + 6);
        btn_menu = '0;
        tick(LAT + 4);
        btn_confirm = 1'b0; sw_card = 1'b0; sw_card_ok = 1'b0;
        exp_level(LAT, K_CARD, 4'd0);
        tick(LAT + 4);

        // Confirm chatter, then stable high.
        for (int i = 0; i < 10; i++) begin
            btn_confirm = (i % 2 == 0);
            if (!DB_EN && (i % 2 == 0)) exp_pulse(3, 3'b000, 1'b1);
            tick(1);
        end
        btn_confirm = 1'b1;
        exp_pulse(LAT, 3'b000, 1'b1);
        tick(LAT + 6);
        settle();

        // Reset in the middle of a confirm debounce with the button held.
        btn_confirm = 1'b1;
        if (!DB_EN) exp_pulse(3, 3'b000, 1'b1);
        tick(4);
        rst = 1'b1;
        tick(1);
        check_reset_outputs();
        tick(1);
        rst = 1'b0;
        exp_pulse(LAT, 3'b000, 1'b1);
        exp_level(2, K_DEP, 4'b1011);
        tick(LAT + 6);
        settle();

        tick(5);
        check("pulses_pending", 32'(pq.size()), 32'd0);
        check("levels_pending", 32'(lq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/atm_panel_encoder.md
ATM_PANEL_ENCODER -- requirements
Module: atm_panel_encoder

Interface
REQ-001 Parameter DB_LIMIT, default 50000, consecutive stable cycles required before a debounced input changes (legal range 1..65535).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 sw_card  input  1  raw slide switch, 1 = card inserted.
REQ-005 sw_card_ok  input  1  raw slide switch, 1 = inserted card valid.
REQ-006 btn_menu  input  5  raw buttons: [0] balance, [1] rapid withdraw, [2] withdraw, [3] deposit, [4] exit.
REQ-007 btn_confirm  input  1  raw confirm button.
REQ-008 sw_amount  input  4  raw amount switches.
REQ-009 card_input  output  2  00 no card, 01 invalid, 10 valid; 11 never driven.
REQ-010 menu_input  output  3  one-cycle menu code 001..101, else 000.
REQ-011 confirm_btn  output  1  one-cycle confirm pulse.
REQ-012 deposit_amount  output  4  synchronized sw_amount.
REQ-013 withdraw_amount  output  3  synchronized sw_amount[2:0].

Function
REQ-014 Every raw input SHALL pass through a two-flop synchronizer; sync value visible 2 cycles after raw change.
REQ-015 Each of the 8 control inputs (sw_card, sw_card_ok, btn_menu[4:0], btn_confirm) SHALL have its own debouncer: counter clears when sync == debounced; increments while they differ; on reaching DB_LIMIT consecutive differing cycles, debounced takes sync value and counter clears.
REQ-016 Any single-cycle agreement of sync with debounced during counting SHALL restart the count (glitch rejection).
REQ-017 card_input SHALL be registered: 00 when debounced sw_card = 0; 10 when sw_card = 1 and sw_card_ok = 1; 01 when sw_card = 1 and sw_card_ok = 0.
REQ-018 Menu encoder states: IDLE, ARMED-LOCK (LOCKED); IDLE with any debounced menu button rising SHALL emit exactly one cycle of code (bit0->001, bit1->010, bit2->011, bit3->100, bit4->101) and go LOCKED.
REQ-019 Simultaneous rising buttons SHALL resolve to lowest index; others ignored.
REQ-020 LOCKED SHALL suppress all menu codes until every debounced menu button is 0 for one cycle, then return IDLE.
REQ-021 confirm_btn SHALL pulse exactly one cycle per debounced btn_confirm rising edge; holding produces no repeats.
REQ-022 Latency raw edge to menu_input/confirm_btn pulse SHALL be DB_LIMIT+3 cycles with raw held stable.
REQ-023 Menu and confirm pulses in the same cycle SHALL both be emitted; card_input change SHALL not cancel either.
REQ-024 deposit_amount/withdraw_amount SHALL be the synchronizer outputs (no debounce), latency 2 cycles.

Reset
REQ-025 rst SHALL force card_input=00, menu_input=000, confirm_btn=0, amounts=0, all synchronizer/debounced flops and counters=0, menu encoder=IDLE.
REQ-026 A button held through reset release SHALL be seen as a fresh rising edge after debounce (one pulse).
REQ-027 Reset asserted mid-count SHALL discard the count; no pulse emitted from pre-reset activity.

Configuration
REQ-028 Macro ATM_PANEL_DEBOUNCE_EN defined: debouncers per REQ-015/016, DB_LIMIT honored.
REQ-029 Macro undefined: debounced = synchronizer output, DB_LIMIT ignored, pulse latency 3 cycles; all other behaviour identical.

Structure
REQ-030 Shared package atm_pkg SHALL hold card codes (NO_CARD, CARD_INVALID, CARD_VALID) and menu codes (MENU_NONE, MENU_BALANCE, MENU_RAPID, MENU_WITHDRAW, MENU_DEPOSIT, MENU_EXIT), also used by the ATM controller.
REQ-031 Sub-module panel_debounce (one bit: synchronizer + debouncer, parameter DB_LIMIT, macro-controlled) SHALL be instantiated 8 times; amount sync stays in top.

Verification (DB_LIMIT=4, macro defined unless noted)
REQ-032 btn_menu=00100 held 20 cycles -> menu_input=011 for exactly one cycle at edge+7; no further codes.
REQ-033 btn_confirm toggles 1 cycle high/1 low for 10 cycles then held high -> no pulse during toggling; single pulse 7 cycles after stable-high start.
REQ-034 btn_menu=10010 same cycle -> menu_input=010 once; release bit1 keeping bit4 -> no 101 pulse until all released and bit4 re-pressed.
REQ-035 sw_card=1, sw_card_ok=0 -> card_input=01; sw_card_ok->1 -> 10; sw_card->0 -> 00; each after debounce + 1 register cycle.
REQ-036 rst pulsed at count 2 of btn_confirm debounce with button held -> no pulse before reset; exactly one pulse DB_LIMIT+3 cycles after release.
REQ-037 Macro undefined, btn_menu[0] raw rise -> menu_input=001 at edge+3; sw_amount=1011 -> deposit_amount=1011, withdraw_amount=011 at edge+2.
